// File: rtl/peri_wb2reg_bridge_if.sv
// Bus bundle between a wishbone-classic master and the peripheral reg bus.
// The "slave" modport is the bridge's view: it is the wishbone slave and
// drives the reg bus. The "master" modport is the opposite view, i.e. the
// wishbone master together with the reg-bus peripheral.
interface peri_wb2reg_bridge_if #(
  parameter int AW = 11,
  parameter int DW = 32
);
  // Wishbone side
  logic            wbs_cyc_i;
  logic            wbs_stb_i;
  logic [AW-1:0]   wbs_adr_i;
  logic            wbs_we_i;
  logic [DW-1:0]   wbs_dat_i;
  logic [DW/8-1:0] wbs_sel_i;
  logic [DW-1:0]   wbs_dat_o;
  logic            wbs_ack_o;
  logic            wbs_err_o;

  // Reg-bus side
  logic            reg_cs;
  logic            reg_wr;
  logic [AW-1:0]   reg_addr;
  logic [DW-1:0]   reg_wdata;
  logic [DW/8-1:0] reg_be;
  logic [DW-1:0]   reg_rdata;
  logic            reg_ack;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_adr_i, wbs_we_i, wbs_dat_i, wbs_sel_i,
    output wbs_dat_o, wbs_ack_o, wbs_err_o,
    output reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
    input  reg_rdata, reg_ack
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_adr_i, wbs_we_i, wbs_dat_i, wbs_sel_i,
    input  wbs_dat_o, wbs_ack_o, wbs_err_o,
    input  reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
    output reg_rdata, reg_ack
  );
endinterface

// File: rtl/peri_wb2reg_bridge.sv
// Wishbone-classic slave to peripheral reg-bus master bridge.
// One wishbone cycle becomes one reg_cs/reg_ack transaction. Request and
// response are both registered; a reg access that never acks is closed with
// an error response after TO_CYCLES cycles, counted in err_cnt, and its
// address is kept in err_addr for debug.
module peri_wb2reg_bridge #(
  parameter int              AW        = 11,
  parameter int              DW        = 32,
  parameter int unsigned     TO_CYCLES = 255,          // 0 disables the timeout
  parameter logic [DW-1:0]   ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic                 mclk,
  input  logic                 h_reset_n,
  peri_wb2reg_bridge_if.slave  bus,
  output logic [7:0]           err_cnt,
  output logic [AW-1:0]        err_addr
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP
  } state_t;

  // Last timeout counter value before the access is declared hung.
  localparam logic [7:0] TO_LAST = 8'(TO_CYCLES - 1);

  state_t          r_state,     w_state_nxt;
  logic [7:0]      r_to_cnt,    w_to_cnt;
  logic            r_cs,        w_cs;
  logic            r_wr,        w_wr;
  logic [AW-1:0]   r_addr,      w_addr;
  logic [DW-1:0]   r_wdata,     w_wdata;
  logic [DW/8-1:0] r_be,        w_be;
  logic [DW-1:0]   r_dat,       w_dat;
  logic            r_ack,       w_ack;
  logic            r_err,       w_err;
  logic [7:0]      r_err_cnt,   w_err_cnt;
  logic [AW-1:0]   r_err_addr,  w_err_addr;
  logic            w_to_hit;

  assign w_to_hit = (TO_CYCLES != 0) && (r_to_cnt == TO_LAST);

  // Next-state and next-output decode for the request/response FSM.
  always_comb begin
    // NOTE: every signal gets its hold value first, so no branch can leave
    // one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_to_cnt    = r_to_cnt;
    w_cs        = r_cs;
    w_wr        = r_wr;
    w_addr      = r_addr;
    w_wdata     = r_wdata;
    w_be        = r_be;
    w_dat       = r_dat;
    w_ack       = 1'b0;           // ack/err are single-cycle pulses
    w_err       = 1'b0;
    w_err_cnt   = r_err_cnt;
    w_err_addr  = r_err_addr;

    unique case (r_state)
      ST_IDLE: begin
        if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
          w_addr      = bus.wbs_adr_i;
          w_wr        = bus.wbs_we_i;
          w_wdata     = bus.wbs_dat_i;
          w_be        = bus.wbs_sel_i;
          w_cs        = 1'b1;
          w_to_cnt    = 8'd0;
          w_state_nxt = ST_REQ;
        end
      end

      ST_REQ: begin
        w_to_cnt = r_to_cnt + 8'd1;
        // A master abort wins: acking a cycle the master has already left
        // would hand a stray ack to whatever cycle comes next.
        if (!bus.wbs_cyc_i) begin
          w_cs        = 1'b0;
          w_state_nxt = ST_IDLE;
        end else if (bus.reg_ack) begin
          w_cs        = 1'b0;
          w_dat       = r_wr ? '0 : bus.reg_rdata;
          w_ack       = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (w_to_hit) begin
          w_cs        = 1'b0;
          w_dat       = r_wr ? '0 : ERR_DATA;
          w_ack       = 1'b1;
          w_err       = 1'b1;
          w_err_cnt   = (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;
          w_err_addr  = r_addr;
          w_state_nxt = ST_RESP;
        end
      end

      ST_RESP: begin
        // The ack pulse ends here; a strobe still high is the old request.
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset; reset aborts any
  // transaction in flight and clears every output.
  always_ff @(posedge mclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!h_reset_n) begin
      r_state    <= ST_IDLE;
      r_to_cnt   <= 8'd0;
      r_cs       <= 1'b0;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_dat      <= '0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_err_cnt  <= 8'd0;
      r_err_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_to_cnt   <= w_to_cnt;
      r_cs       <= w_cs;
      r_wr       <= w_wr;
      r_addr     <= w_addr;
      r_wdata    <= w_wdata;
      r_be       <= w_be;
      r_dat      <= w_dat;
      r_ack      <= w_ack;
      r_err      <= w_err;
      r_err_cnt  <= w_err_cnt;
      r_err_addr <= w_err_addr;
    end
  end

  assign bus.reg_cs    = r_cs;
  assign bus.reg_wr    = r_wr;
  assign bus.reg_addr  = r_addr;
  assign bus.reg_wdata = r_wdata;
  assign bus.reg_be    = r_be;
  assign bus.wbs_dat_o = r_dat;
  assign bus.wbs_ack_o = r_ack;
  assign bus.wbs_err_o = r_err;
  assign err_cnt       = r_err_cnt;
  assign err_addr      = r_err_addr;

endmodule

// File: doc/peri_wb2reg_bridge.md
Name: peri_wb2reg_bridge

Overview:
- Wishbone-classic slave to reg-bus master bridge, directly upstream of the peripheral top.
- Converts one wishbone cycle into one reg_cs/reg_ack transaction on the peripheral reg bus, which serves the dig2ana, RTC and IR sub-blocks.
- Registers the request and the response, and closes hung accesses with a timeout error response.
- Keeps a saturating error counter and a capture of the last failing address for debug.

Parameters:
AW, 11, reg/wishbone address width
DW, 32, data width
TO_CYCLES, 255, reg_cs cycles without reg_ack before timeout; 0 disables timeout
ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout

Ports:
mclk  in  1  system clock
h_reset_n  in  1  synchronous active-low reset
wbs_cyc_i  in  1  wishbone cycle
wbs_stb_i  in  1  wishbone strobe
wbs_adr_i  in  AW  byte address
wbs_we_i  in  1  write enable
wbs_dat_i  in  DW  write data
wbs_sel_i  in  DW/8  byte select
wbs_dat_o  out  DW  read data
wbs_ack_o  out  1  transfer acknowledge
wbs_err_o  out  1  timeout error (asserted together with wbs_ack_o)
reg_cs  out  1  reg-bus chip select
reg_wr  out  1  reg-bus write
reg_addr  out  AW  reg-bus address
reg_wdata  out  DW  reg-bus write data
reg_be  out  DW/8  reg-bus byte enables
reg_rdata  in  DW  reg-bus read data
reg_ack  in  1  reg-bus acknowledge
err_cnt  out  8  saturating timeout count
err_addr  out  AW  address of the most recent timed-out access

Behaviour:
Reset and clocking:
- One clock, mclk. Reset is synchronous and active-low on h_reset_n.
- At the first mclk edge with h_reset_n=0, all outputs go to 0 and the FSM goes to IDLE.
- Reset mid-transaction aborts it: no wishbone ack is issued, and reg_cs drops at that same edge.

FSM states: IDLE, REQ, RESP. All outputs are registered.

IDLE:
- If wbs_cyc_i & wbs_stb_i are sampled high, latch adr/we/dat/sel into reg_addr/reg_wr/reg_wdata/reg_be, set reg_cs=1, clear the timeout counter, and go to REQ.
- reg_* fields hold their last values while reg_cs=0.

REQ:
- reg_cs=1; the counter increments each cycle.
- reg_ack=1 sampled (takes priority over timeout in the same cycle):
  - reg_cs←0.
  - wbs_dat_o←reg_rdata for a read, 0 for a write.
  - wbs_ack_o←1; go to RESP.
- No reg_ack and counter==TO_CYCLES-1 with TO_CYCLES≠0:
  - reg_cs←0; wbs_ack_o←1; wbs_err_o←1.
  - wbs_dat_o←ERR_DATA for a read, 0 for a write.
  - err_cnt←min(err_cnt+1,255); err_addr←reg_addr; go to RESP.
- wbs_cyc_i=0 sampled (master abort): reg_cs←0, go to IDLE, no ack, no error count. A late reg_ack after this is ignored.

RESP:
- wbs_ack_o and wbs_err_o are high for exactly this one cycle, then cleared; go to IDLE.
- A strobe still high in the RESP cycle is not treated as a new request.
- reg_cs is low for at least one cycle between consecutive transactions.

Other rules:
- Latency: request sampled at edge N → reg_cs high after N. A reg_ack sampled at edge M → wbs_ack high for the cycle after M.
- For a slave with registered ack, wishbone ack is 3 cycles after the strobe is sampled.
- Throughput: one transaction per 4 cycles minimum with a 1-cycle-ack slave.
- reg_ack while reg_cs=0 is ignored.
- wbs_dat_o holds its value until the next response.
- err_cnt saturates at 255 and is cleared only by reset.
- Timeout counter width is 8 bits; TO_CYCLES must be ≤255.

Test Plan:
1. Read addr 11'h084 with slave returning reg_rdata=32'h1234_5678, ack 1 cycle after reg_cs → reg_cs high 2 cycles; wbs_ack_o 1-cycle pulse with wbs_dat_o=32'h1234_5678; wbs_err_o=0.
2. Write addr 11'h100, data 32'hA5A5_0F0F, sel 4'b0101 → reg_wr=1, reg_be=4'b0101, reg_wdata=32'hA5A5_0F0F during reg_cs; wbs_ack_o pulse; wbs_dat_o=0.
3. Read with slave never acking, TO_CYCLES=255 → reg_cs high exactly 255 cycles, then wbs_ack_o=wbs_err_o=1 with wbs_dat_o=32'hDEAD_BEEF; err_cnt=1; err_addr equals the request address. Repeat 300 timeouts → err_cnt stays 255.
4. reg_ack arriving in the same cycle the counter reaches TO_CYCLES-1 → normal ack, wbs_err_o=0, err_cnt unchanged.
5. Master drops wbs_cyc_i 3 cycles into REQ, then slave acks late → reg_cs drops, no wbs_ack_o, late ack ignored. Next request completes normally.
6. Back-to-back reads with strobe re-asserted immediately after ack, and h_reset_n=0 asserted mid-REQ → second read accepted only after RESP. On reset, all outputs are 0 on the next edge, no ack, and the FSM is in IDLE.
